// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, drives the combinational instruction
// memory, and fills the IF/ID register with stall, branch-redirect and halt handling.
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [63:0] HALT_ADDR = 64'h054,
    parameter int          CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [63:0]      BranchTarget,
    output logic [63:0]      InstrAddress,
    input  logic [31:0]      InstrData,
    output logic [31:0]      IfIdInstr,
    output logic [63:0]      IfIdPC,
    output logic             IfIdValid,
    output logic             Halted,
    output logic [CNT_W-1:0] FetchCount
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [63:0]      pc_r;
    logic [63:0]      pc_next_s;
    logic [31:0]      instr_r;
    logic [31:0]      instr_next_s;
    logic [63:0]      ifid_pc_r;
    logic [63:0]      ifid_pc_next_s;
    logic             valid_r;
    logic             valid_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Redirect targets are word-aligned; the low two bits are deliberately dropped.
    logic unused_tgt_s;
    assign unused_tgt_s = ^BranchTarget[1:0];

    // Next-state and IF/ID update, with branch taking priority over stall.
    always_comb begin
        state_next_s   = state_r;
        pc_next_s      = pc_r;
        instr_next_s   = instr_r;
        ifid_pc_next_s = ifid_pc_r;
        valid_next_s   = valid_r;
        cnt_next_s     = cnt_r;
        if (BranchTaken) begin
            pc_next_s    = {BranchTarget[63:2], 2'b00};
            valid_next_s = 1'b0;
            state_next_s = ST_RUN;
        end else if (Stall) begin
            pc_next_s    = pc_r;
            valid_next_s = valid_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    instr_next_s   = InstrData;
                    ifid_pc_next_s = pc_r;
                    valid_next_s   = 1'b1;
                    cnt_next_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    pc_next_s      = pc_r + 64'd4;
                    if (pc_r == HALT_ADDR) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_HALT: begin
                    // PC parks one word past the last instruction while IF/ID drains.
                    valid_next_s = 1'b0;
                end
                default: begin
                    state_next_s = ST_RUN;
                    valid_next_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch state, PC and IF/ID pipeline register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r   <= ST_RUN;
            pc_r      <= RESET_PC;
            instr_r   <= 32'h0;
            ifid_pc_r <= 64'h0;
            valid_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            instr_r   <= instr_next_s;
            ifid_pc_r <= ifid_pc_next_s;
            valid_r   <= valid_next_s;
            cnt_r     <= cnt_next_s;
        end
    end

    assign InstrAddress = pc_r;
    assign IfIdInstr    = instr_r;
    assign IfIdPC       = ifid_pc_r;
    assign IfIdValid    = valid_r;
    assign FetchCount   = cnt_r;
    assign Halted       = (state_r == ST_HALT);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 pipeline. It sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory address. It captures the returned 32-bit instruction word into the IF/ID pipeline register.
- Handles stall and branch-redirect requests from decode/execute, and halts fetch after a programmed end address.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
HALT_ADDR, 64'h054, address of last instruction; fetch stops after it is latched.
CNT_W, 32, width of the fetched-instruction counter.

Ports:
CLK  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Stall  input  1  hold PC and IF/ID contents this cycle.
BranchTaken  input  1  redirect fetch to BranchTarget; flush the wrong-path fetch.
BranchTarget  input  64  redirect address; bits [1:0] ignored.
InstrAddress  output  64  address to instruction memory (= PC).
InstrData  input  32  instruction word returned combinationally for InstrAddress.
IfIdInstr  output  32  latched instruction.
IfIdPC  output  64  address of latched instruction.
IfIdValid  output  1  IfIdInstr holds a real instruction.
Halted  output  1  fetch halted.
FetchCount  output  CNT_W  number of instructions latched with valid=1.

Behaviour:
- Reset (async, immediate, independent of CLK): PC=RESET_PC, IfIdInstr=0, IfIdPC=0, IfIdValid=0, FetchCount=0, state=RUN, Halted=0.
- InstrAddress = PC combinationally. Instruction memory is zero-latency, so InstrData is valid in the same cycle.
- State machine RUN/HALT; Halted = (state==HALT).
- Priority per rising edge: BranchTaken > Stall > normal.
- BranchTaken (either state):
  - PC <= {BranchTarget[63:2],2'b00}.
  - IfIdValid <= 0; IfIdInstr/IfIdPC may update but are don't-care when invalid.
  - FetchCount holds.
  - State <= RUN. A redirect out of HALT resumes fetch.
- Stall (no branch): PC, IfIdInstr, IfIdPC, IfIdValid, FetchCount, state all hold.
- Normal, RUN:
  - IfIdInstr <= InstrData; IfIdPC <= PC; IfIdValid <= 1; FetchCount <= FetchCount+1.
  - If PC==HALT_ADDR: PC <= PC+4 and state <= HALT.
  - Else PC <= PC+4.
- Normal, HALT:
  - PC holds at HALT_ADDR+4; IfIdValid <= 0 (the last instruction drains); FetchCount holds.
- PC arithmetic: 64-bit, PC+4 wraps modulo 2^64 with no flag.
- FetchCount wraps modulo 2^CNT_W.
- Reset asserted mid-stall or mid-branch: reset wins; all state cleared; first edge after deassertion fetches RESET_PC.
- X on InstrData (undefined address) is latched unchanged; the stage does no detection.
- Single clock domain; no combinational path from Stall/BranchTaken to InstrAddress.

Test Plan:
1. Reset release, free run: cycle 0 InstrAddress=0x000. After edge 1: IfIdPC=0x000, IfIdInstr=F84003E9, IfIdValid=1, FetchCount=1, InstrAddress=0x004. After edge 6: IfIdInstr=AA0B014A, IfIdPC=0x014.
2. Stall 3 cycles with PC=0x014: InstrAddress stays 0x014, IfIdInstr stays F84203ED, FetchCount stays 5. On release, next edge latches AA0B014A.
3. Branch redirect: with PC=0x02C, assert BranchTaken, target 0x020.
   - Next edge: InstrAddress=0x020, IfIdValid=0, FetchCount unchanged.
   - Following edge: IfIdInstr=8B0901AD, IfIdValid=1.
   - Target 0x023 must yield PC=0x020.
4. Branch and Stall asserted together at PC=0x018, target 0x02C: branch wins, PC=0x02C, IfIdValid=0.
5. Halt: run from 0x034 to 0x054.
   - Edge latching F84283EA (IfIdPC=0x054): Halted=1, InstrAddress=0x058.
   - Next edge: IfIdValid=0. FetchCount frozen for 10 further cycles.
   - BranchTaken to 0x000 then clears Halted and resumes fetch.
6. Async reset pulse between clock edges while PC=0x030, IfIdValid=1: PC=0, IfIdValid=0, FetchCount=0, Halted=0 immediately, without waiting for CLK.
